// File: rtl/genie_split.sv
// genie_split: fans one valid/ready/eop beat out to every output in its destination mask.
// Latency: zero (outputs are combinational); outputs that already took the beat are not re-offered it.
// Backpressure: input is released only once every targeted output has accepted. Option: GENIE_SPLIT_PKT_LOCK_EN.
module genie_split #(
  parameter int NO    = 2,
  parameter int WIDTH = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [((WIDTH > 0) ? WIDTH : 1)-1:0] i_data,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic                                 i_eop,
  input  logic [NO-1:0]                        i_mask,
  output logic [NO-1:0]                        o_valid,
  output logic [NO*((WIDTH > 0) ? WIDTH : 1)-1:0] o_data,
  output logic [NO-1:0]                        o_eop,
  input  logic [NO-1:0]                        i_ready
);

  // Outputs that have already accepted the beat currently on the input.
  logic [NO-1:0] sent_q;
  logic [NO-1:0] sent_d;
  logic [NO-1:0] eff_mask;
  logic [NO-1:0] take;
  logic [NO-1:0] done;
  logic          consume;

`ifdef GENIE_SPLIT_PKT_LOCK_EN
  // The destination of a packet is fixed by its first beat.
  logic          locked_q;
  logic          locked_d;
  logic [NO-1:0] mask_q;
  logic [NO-1:0] mask_d;

  assign eff_mask = locked_q ? mask_q : i_mask;

  // Capture the mask on the first consumed beat; unlock on a consumed eop beat.
  always_comb begin
    locked_d = locked_q;
    mask_d   = mask_q;
    if (consume) begin
      if (!locked_q) begin
        mask_d = i_mask;
      end
      locked_d = !i_eop;
    end
  end

  // Lock state registers; reset returns to the unlocked idle state.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q <= 1'b0;
      mask_q   <= '0;
    end else begin
      locked_q <= locked_d;
      mask_q   <= mask_d;
    end
  end
`else
  assign eff_mask = i_mask;
`endif

  // Offer the beat to targeted outputs that have not taken it yet; o_valid never depends on i_ready.
  always_comb begin
    o_valid = {NO{i_valid & ~reset}} & eff_mask & ~sent_q;
    take    = o_valid & i_ready;
    done    = ~eff_mask | sent_q | take;
    o_ready = ~reset & (&done);
    o_eop   = {NO{i_eop}};
    consume = i_valid & o_ready;
  end

  // Every output sees the same data; with no data path the bus is tied off.
  if (WIDTH > 0) begin : g_data
    assign o_data = {NO{i_data}};
  end else begin : g_nodata
    assign o_data = '0;
  end

  // Accumulate acceptances within a beat and clear once the beat is consumed.
  always_comb begin
    sent_d = sent_q;
    if (consume) begin
      sent_d = '0;
    end else if (i_valid) begin
      sent_d = sent_q | take;
    end
  end

  // Reset abandons partial progress so the beat is re-offered in full.
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule

// File: tb/tb_genie_split.sv
// tb_genie_split: directed vectors for genie_split with NO=3, WIDTH=8.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after it.
// Per-output handshake counts are accumulated on each rising edge.
module tb_genie_split;

  logic        clk;
  logic        reset;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic        i_eop;
  logic [2:0]  i_mask;
  logic [2:0]  o_valid;
  logic [23:0] o_data;
  logic [2:0]  o_eop;
  logic [2:0]  i_ready;

  int n_vec;
  int n_err;
  int acc [3];
  int a0, a1, a2;

  genie_split #(.NO(3), .WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_eop   (i_eop),
    .i_mask  (i_mask),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_eop   (o_eop),
    .i_ready (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed handshakes per output.
  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (o_valid[j] && i_ready[j]) acc[j] <= acc[j] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [2:0] m, input logic [7:0] d,
                       input logic e, input logic [2:0] r);
    i_valid = v;
    i_mask  = m;
    i_data  = d;
    i_eop   = e;
    i_ready = r;
    #1;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset   = 1'b1;
    i_valid = 1'b1;
    i_mask  = 3'b111;
    i_data  = 8'h3C;
    i_eop   = 1'b1;
    i_ready = 3'b111;
    #2;
    check("rst_valid", {29'd0, o_valid}, 32'h0);
    check("rst_ready", {31'd0, o_ready}, 32'h0);
    next_cycle();
    reset = 1'b0;

    // Basic fan-out, all ready: consumed in one cycle.
    apply(1'b1, 3'b101, 8'hA5, 1'b1, 3'b111);
    check("fan_valid", {29'd0, o_valid}, 32'h5);
    check("fan_data0", {24'd0, o_data[7:0]}, 32'hA5);
    check("fan_data2", {24'd0, o_data[23:16]}, 32'hA5);
    check("fan_eop", {29'd0, o_eop}, 32'h7);
    check("fan_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();

    // Stalled beat: nothing taken, everything still offered next cycle.
    apply(1'b1, 3'b111, 8'h11, 1'b0, 3'b000);
    check("stall_valid", {29'd0, o_valid}, 32'h7);
    check("stall_ready", {31'd0, o_ready}, 32'h0);
    check("stall_eop", {29'd0, o_eop}, 32'h0);
    next_cycle();

    // Partial acceptance across two cycles.
    a0 = acc[0]; a1 = acc[1]; a2 = acc[2];
    apply(1'b1, 3'b111, 8'h22, 1'b1, 3'b001);
    check("part0_valid", {29'd0, o_valid}, 32'h7);
    check("part0_ready", {31'd0, o_ready}, 32'h0);
    next_cycle();
    apply(1'b1, 3'b111, 8'h22, 1'b1, 3'b110);
    check("part1_valid", {29'd0, o_valid}, 32'h6);
    check("part1_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();
    check("part_acc0", acc[0] - a0, 32'd1);
    check("part_acc1", acc[1] - a1, 32'd1);
    check("part_acc2", acc[2] - a2, 32'd1);

    // Zero mask: dropped in the same cycle.
    apply(1'b1, 3'b000, 8'h33, 1'b1, 3'b000);
    check("zero_valid", {29'd0, o_valid}, 32'h0);
    check("zero_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();

    // Reset mid-beat re-offers the beat in full.
    apply(1'b1, 3'b011, 8'h44, 1'b1, 3'b001);
    check("rmid_valid", {29'd0, o_valid}, 32'h3);
    check("rmid_ready", {31'd0, o_ready}, 32'h0);
    next_cycle();
    reset = 1'b1;
    apply(1'b1, 3'b011, 8'h44, 1'b1, 3'b000);
    check("rmid_rst_valid", {29'd0, o_valid}, 32'h0);
    check("rmid_rst_ready", {31'd0, o_ready}, 32'h0);
    next_cycle();
    reset = 1'b0;
    apply(1'b1, 3'b011, 8'h44, 1'b1, 3'b000);
    check("rmid_after_valid", {29'd0, o_valid}, 32'h3);
    check("rmid_after_ready", {31'd0, o_ready}, 32'h0);
    apply(1'b1, 3'b011, 8'h44, 1'b1, 3'b011);
    check("rmid_done_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();

    // Back-to-back beats, all ready.
    a0 = acc[0]; a1 = acc[1]; a2 = acc[2];
    apply(1'b1, 3'b001, 8'h51, 1'b1, 3'b111);
    check("b2b0_valid", {29'd0, o_valid}, 32'h1);
    check("b2b0_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();
    apply(1'b1, 3'b010, 8'h52, 1'b1, 3'b111);
    check("b2b1_valid", {29'd0, o_valid}, 32'h2);
    check("b2b1_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();
    apply(1'b1, 3'b100, 8'h53, 1'b1, 3'b111);
    check("b2b2_valid", {29'd0, o_valid}, 32'h4);
    check("b2b2_ready", {31'd0, o_ready}, 32'h1);
    check("b2b2_data2", {24'd0, o_data[23:16]}, 32'h53);
    next_cycle();
    apply(1'b1, 3'b111, 8'h54, 1'b1, 3'b111);
    check("b2b3_valid", {29'd0, o_valid}, 32'h7);
    check("b2b3_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();
    check("b2b_acc0", acc[0] - a0, 32'd2);
    check("b2b_acc1", acc[1] - a1, 32'd2);
    check("b2b_acc2", acc[2] - a2, 32'd2);

    // Three-beat packet whose later beats present a different mask.
    apply(1'b1, 3'b010, 8'h61, 1'b0, 3'b111);
    check("pkt0_valid", {29'd0, o_valid}, 32'h2);
    check("pkt0_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();
`ifdef GENIE_SPLIT_PKT_LOCK_EN
    apply(1'b1, 3'b100, 8'h62, 1'b0, 3'b111);
    check("pkt1_valid", {29'd0, o_valid}, 32'h2);
    next_cycle();
    apply(1'b1, 3'b100, 8'h63, 1'b1, 3'b111);
    check("pkt2_valid", {29'd0, o_valid}, 32'h2);
    check("pkt2_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();
`else
    apply(1'b1, 3'b100, 8'h62, 1'b0, 3'b111);
    check("pkt1_valid", {29'd0, o_valid}, 32'h4);
    next_cycle();
    apply(1'b1, 3'b100, 8'h63, 1'b1, 3'b111);
    check("pkt2_valid", {29'd0, o_valid}, 32'h4);
    check("pkt2_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();
`endif
    apply(1'b1, 3'b100, 8'h71, 1'b1, 3'b111);
    check("pkt_next_valid", {29'd0, o_valid}, 32'h4);
    check("pkt_next_ready", {31'd0, o_ready}, 32'h1);
    next_cycle();

    // Idle input: nothing offered.
    apply(1'b0, 3'b111, 8'h00, 1'b0, 3'b111);
    check("idle_valid", {29'd0, o_valid}, 32'h0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/genie_split.md
Name: genie_split

Overview:
- Single-input, multi-output packet fan-out stage.
- Takes one valid/ready/eop stream and replicates each beat to every output selected by a per-beat destination mask.
- Sits upstream of the merge arbiters: each output feeds one input of a downstream merge.
- Supports partial acceptance: outputs that have already taken the current beat are not re-offered it. The input is released only once every targeted output has accepted.

Parameters:
NO, 2, number of outputs (>=1)
WIDTH, 1, data width per beat; 0 means no data path (valid/ready/eop only)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_data  in  WIDTH  input beat data
i_valid  in  1  input beat valid
o_ready  out  1  input beat consumed this cycle
i_eop  in  1  input end of packet
i_mask  in  NO  destination mask; bit j targets output j
o_valid  out  NO  per-output valid
o_data  out  NO*WIDTH  per-output data; slice j = i_data
o_eop  out  NO  per-output eop; bit j = i_eop
i_ready  in  NO  per-output ready

Behaviour:
- Single clock clk. reset is synchronous, active-high, sampled on the rising edge of clk.
- State:
  - sent[NO-1:0]: outputs that have already accepted the current beat.
  - eff_mask: effective destination mask (see Optional Feature; without it, eff_mask = i_mask).
- Combinational outputs (zero latency, no pipeline register):
  - o_valid[j] = i_valid & eff_mask[j] & !sent[j] & !reset
  - o_data slice j = i_data; o_eop[j] = i_eop (unqualified, meaningful only with o_valid[j])
  - take[j] = o_valid[j] & i_ready[j]
  - o_ready = !reset & AND over j of (!eff_mask[j] | sent[j] | take[j])
- Beat consumed when i_valid & o_ready. On that clock edge sent <= 0.
- Otherwise, while i_valid: sent <= sent | take.
- While !i_valid: sent holds; it is always 0 in legal use.
- Upstream must hold i_data, i_eop and i_mask stable while i_valid & !o_ready. Changing them mid-beat is illegal and behaviour is undefined.
- Zero mask with i_valid: o_ready=1 the same cycle; beat dropped, no o_valid asserted.
- All targeted outputs ready in the same cycle: beat consumed in one cycle.
- Each targeted output sees exactly one o_valid&i_ready per beat (no duplication).
- No combinational path from i_ready[j] to o_valid[k] for any j, k. A combinational path from i_ready to o_ready is permitted.
- Reset:
  - sent <= 0.
  - While reset is high, all o_valid and o_ready are 0.
  - Reset mid-beat abandons partial progress; the beat is re-offered in full after reset.
- Reset values: o_valid=0, o_ready=0, sent=0, lock state idle.
- NO=1 degenerates to a pass-through gated by the mask bit.

Optional Feature:
- Macro: GENIE_SPLIT_PKT_LOCK_EN
- Defined:
  - i_mask is sampled only on the first beat of a packet (first consumed beat after reset or after a consumed eop beat).
  - It is held in a register for the rest of the packet: eff_mask = locked ? mask_reg : i_mask.
  - locked is set when a non-eop beat is consumed and cleared when an eop beat is consumed.
  - mask_reg loads i_mask on that first beat.
  - Reset clears locked.
- Undefined: eff_mask = i_mask on every beat; no lock register exists.

Test Plan:
- NO=3, WIDTH=8, mask=3'b101, data=0xA5, eop=1, all i_ready=1 -> o_valid=3'b101 with o_data 0xA5 on outputs 0 and 2; o_ready=1 in the same cycle; sent stays 0.
- Partial acceptance: mask=3'b111, i_ready=3'b001 for cycle 0, then 3'b110 for cycle 1 -> cycle 0: o_ready=0, sent becomes 3'b001. Cycle 1: o_valid=3'b110, o_ready=1, sent back to 0. Output 0 accepts exactly once.
- mask=3'b000, i_valid=1, i_ready=0 -> o_ready=1, o_valid=0; beat dropped.
- Reset mid-beat: mask=3'b011, output 0 takes the beat, then reset pulses 1 cycle -> o_valid=0 and o_ready=0 during reset. After reset, o_valid=3'b011 (beat re-offered to both).
- Back-to-back beats: i_ready=3'b111, 4 beats with masks 001, 010, 100, 111 -> 4 consumed in 4 cycles; per-output accept counts 2, 2, 2.
- GENIE_SPLIT_PKT_LOCK_EN defined: 3-beat packet, first beat mask=3'b010, later beats present i_mask=3'b100 -> all 3 beats go only to output 1. The next packet's first beat with mask 3'b100 goes to output 2.
